liu_seq_mult_ctrl: RTL

Sequential controller for the Liu-style approximate multiplier. It time-shares one 2·WIDTH-bit row of carry-free approximate adder cells across all partial products, one partial product per cycle. It accumulates the approximate sum and the per-bit error flags, and hands back the product over a valid/ready handshake. It sits between the operand source and the result consumer, replacing a full combinational partial-product array where area matters more than latency.

---
 rtl/liu_mult_pkg.sv | 23 ++
 rtl/liu_approx_row.sv | 26 ++
 rtl/liu_seq_mult_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/liu_mult_pkg.sv
// Shared definitions for the Liu-style sequential approximate multiplier.
//   state_e  : controller states (IDLE, RUN, FIX, DONE)
//   prod_w() : product/row width for a given operand width (2*w)
//   cnt_w()  : partial-product counter width for a given operand width
package liu_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    // Never below one bit so a degenerate width still yields a legal vector.
    function automatic int unsigned cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/liu_approx_row.sv
// One row of carry-free approximate adder cells.
//   acc_i, pp_i : accumulator and partial product (W bits each)
//   s_o         : approximate sum, s_o[i] = x | g
//   e_o         : error bits,      e_o[i] = x & g
// with x = acc[i]^pp[i] and g = acc[i-1]&pp[i-1] (g = 0 at bit 0).
// acc + pp == s + e (mod 2^W); the generate out of the top bit is dropped.
module liu_approx_row #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] pp_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] e_o
);

    logic [W-1:0] x;
    logic [W-1:0] g;

    always_comb begin
        x   = acc_i ^ pp_i;
        g   = {acc_i[W-2:0] & pp_i[W-2:0], 1'b0};
        s_o = x | g;
        e_o = x & g;
    end

endmodule

// File: rtl/liu_seq_mult_ctrl.sv
// Sequential controller for the Liu-style approximate multiplier.
// One partial product per cycle is folded into the accumulator through a
// shared liu_approx_row; the per-bit error vector is summed exactly.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   in_a, in_b          : multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready : result handshake
//   out_prod            : product (approximate, or exact with recovery)
//   out_err             : accumulated error vector
// Macro ERR_RECOVERY_EN: adds the FIX state, out_prod = acc + err (exact).
module liu_seq_mult_ctrl
    import liu_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [prod_w(WIDTH)-1:0]    out_prod,
    output logic [prod_w(WIDTH)-1:0]    out_err
);

    localparam int unsigned PW = prod_w(WIDTH);
    localparam int unsigned CW = cnt_w(WIDTH);

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]   oerr_q, oerr_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [PW-1:0]   pp;
    logic [PW-1:0]   row_s;
    logic [PW-1:0]   row_e;

    liu_approx_row #(.W(PW)) u_row (
        .acc_i (acc_q),
        .pp_i  (pp),
        .s_o   (row_s),
        .e_o   (row_e)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        oerr_d   = oerr_q;

        pp = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    err_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = row_s;
                err_d = err_q + row_e;
                cnt_d = cnt_q + CW'(1);
                // Every multiplier bit gets its cycle, zero bits included.
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef ERR_RECOVERY_EN
                    state_d = ST_FIX;
`else
                    prod_d  = row_s;
                    oerr_d  = err_d;
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef ERR_RECOVERY_EN
            ST_FIX: begin
                // acc + err is the exact product; it cannot overflow PW bits.
                prod_d  = acc_q + err_q;
                oerr_d  = err_q;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            oerr_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            oerr_q      <= oerr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = prod_q;
    assign out_err   = oerr_q;

endmodule
